// File: rtl/servo_pwm_bank_pkg.sv
// Shared servo constants and helpers used by the regfile taps and the PWM bank.
package servo_pwm_bank_pkg;

    localparam int unsigned N_SERVO         = 6;
    localparam int unsigned SERVO_POS_W     = 7;
    localparam int unsigned DEF_STEP_CYCLES = 390;
    localparam int unsigned DEF_BASE_STEPS  = 128;
    localparam int unsigned DEF_FRAME_STEPS = 2560;
    localparam int unsigned DEF_POS_MAX     = 127;

    function automatic logic [SERVO_POS_W-1:0] clamp_pos(
        input logic [SERVO_POS_W-1:0] pos,
        input int unsigned            pos_max
    );
        if (32'(pos) > pos_max) begin
            return pos_max[SERVO_POS_W-1:0];
        end
        return pos;
    endfunction

endpackage

// File: rtl/servo_pwm_bank_channel.sv
// One servo channel: clamps the position, holds it in a per-frame shadow, drives a registered pulse.
module servo_pwm_channel
    import servo_pwm_bank_pkg::*;
#(
    parameter int unsigned BASE_STEPS = DEF_BASE_STEPS,
    parameter int unsigned POS_MAX    = DEF_POS_MAX,
    parameter int unsigned STEP_W     = 12
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic                   load,
    input  logic                   run,
    input  logic [STEP_W-1:0]      step_cnt,
    input  logic [SERVO_POS_W-1:0] pos_in,
    output logic                   pwm
);

    logic [SERVO_POS_W-1:0] shadow_q, shadow_d;
    logic [STEP_W-1:0]      limit;
    logic                   pwm_q, pwm_d;

    // The boundary cycle compares against the value being loaded, so the pulse starts with it.
    always_comb begin
        shadow_d = load ? clamp_pos(pos_in, POS_MAX) : shadow_q;
        limit    = STEP_W'(BASE_STEPS) + STEP_W'(shadow_d);
        pwm_d    = run && (step_cnt < limit);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// Six-channel hobby-servo PWM generator with shared prescaler/step counter and frame strobe.
module servo_pwm_bank
    import servo_pwm_bank_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int unsigned BASE_STEPS  = DEF_BASE_STEPS,
    parameter int unsigned FRAME_STEPS = DEF_FRAME_STEPS,
    parameter int unsigned POS_MAX     = DEF_POS_MAX
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic                   enable,
    input  logic [SERVO_POS_W-1:0] servo0,
    input  logic [SERVO_POS_W-1:0] servo1,
    input  logic [SERVO_POS_W-1:0] servo2,
    input  logic [SERVO_POS_W-1:0] servo3,
    input  logic [SERVO_POS_W-1:0] servo4,
    input  logic [SERVO_POS_W-1:0] servo5,
    output logic [N_SERVO-1:0]     pwm_out,
    output logic                   frame_start
);

    localparam int unsigned PRE_W  = $clog2(STEP_CYCLES);
    localparam int unsigned STEP_W = $clog2(FRAME_STEPS);

    if ((BASE_STEPS + POS_MAX >= FRAME_STEPS) || (STEP_CYCLES < 2) ||
        (POS_MAX > (2 ** SERVO_POS_W) - 1)) begin : g_bad_params
        $fatal(1, "servo_pwm_bank: invalid timing parameters");
    end

    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic                   fs_q, fs_d;
    logic                   boundary;
    logic                   pre_wrap;
    logic [SERVO_POS_W-1:0] pos [N_SERVO];

    assign pos[0] = servo0;
    assign pos[1] = servo1;
    assign pos[2] = servo2;
    assign pos[3] = servo3;
    assign pos[4] = servo4;
    assign pos[5] = servo5;

    // Counters sit at zero while disabled, so the first enabled cycle is always a boundary.
    always_comb begin
        boundary = enable && (pre_q == '0) && (step_q == '0);
        pre_wrap = (pre_q == PRE_W'(STEP_CYCLES - 1));
        pre_d    = '0;
        step_d   = '0;
        if (enable) begin
            pre_d  = pre_wrap ? '0 : pre_q + PRE_W'(1);
            step_d = step_q;
            if (pre_wrap) begin
                step_d = (step_q == STEP_W'(FRAME_STEPS - 1)) ? '0 : step_q + STEP_W'(1);
            end
        end
        fs_d = boundary;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            pre_q  <= '0;
            step_q <= '0;
            fs_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            step_q <= step_d;
            fs_q   <= fs_d;
        end
    end

    assign frame_start = fs_q;

    for (genvar i = 0; i < N_SERVO; i++) begin : g_ch
        servo_pwm_channel #(
            .BASE_STEPS (BASE_STEPS),
            .POS_MAX    (POS_MAX),
            .STEP_W     (STEP_W)
        ) u_channel (
            .clock      (clock),
            .ctrl_reset (ctrl_reset),
            .load       (boundary),
            .run        (enable),
            .step_cnt   (step_q),
            .pos_in     (pos[i]),
            .pwm        (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a short 128-cycle frame.
module tb_servo_pwm_bank;

    logic       clock = 1'b0;
    logic       ctrl_reset;
    logic       enable;
    logic [6:0] servo0, servo1, servo2, servo3, servo4, servo5;
    logic [5:0] pwm_out;
    logic       frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int hi [6];
    int fs_first;
    int fs_cnt;

    always #5 clock = ~clock;

    servo_pwm_bank #(
        .STEP_CYCLES (4),
        .BASE_STEPS  (8),
        .FRAME_STEPS (32),
        .POS_MAX     (15)
    ) dut (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .enable      (enable),
        .servo0      (servo0),
        .servo1      (servo1),
        .servo2      (servo2),
        .servo3      (servo3),
        .servo4      (servo4),
        .servo5      (servo5),
        .pwm_out     (pwm_out),
        .frame_start (frame_start)
    );

    // Called on the negedge where frame_start is expected; measures one 128-cycle frame
    // and optionally rewrites servo3 at frame cycle chg_k.
    task automatic count_frame(input int chg_k, input logic [6:0] chg_val);
        for (int c = 0; c < 6; c++) hi[c] = 0;
        fs_cnt   = 0;
        fs_first = int'(frame_start);
        for (int k = 0; k < 128; k++) begin
            for (int c = 0; c < 6; c++) if (pwm_out[c]) hi[c]++;
            if (frame_start) fs_cnt++;
            if (k == chg_k) servo3 = chg_val;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        enable     = 1'b1;
        ctrl_reset = 1'b1;
        servo0 = 7'd0;  servo1 = 7'd5;  servo2 = 7'd127;
        servo3 = 7'd2;  servo4 = 7'd15; servo5 = 7'd9;
        for (int r = 0; r < 3; r++) begin
            @(negedge clock);
            n_checks++;
            if (pwm_out !== 6'h00) begin
                n_fail++;
                $display("FAIL reset_pwm cyc%0d: got %h want 00", r, pwm_out);
            end
            n_checks++;
            if (frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_fs cyc%0d: got %b want 0", r, frame_start);
            end
        end
        ctrl_reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL release_fs: got %b want 1", frame_start);
        end
        n_checks++;
        if (pwm_out !== 6'h3f) begin
            n_fail++;
            $display("FAIL release_pwm: got %h want 3f", pwm_out);
        end
    endtask

    task automatic test_basic();
        int exp_hi [6];
        exp_hi = '{32, 52, 92, 40, 92, 68};
        for (int f = 0; f < 2; f++) begin
            count_frame(-1, 7'd0);
            n_checks++;
            if (fs_first !== 1 || fs_cnt !== 1) begin
                n_fail++;
                $display("FAIL basic_fs f%0d: first %0d count %0d want 1 1", f, fs_first, fs_cnt);
            end
            for (int c = 0; c < 6; c++) begin
                n_checks++;
                if (hi[c] !== exp_hi[c]) begin
                    n_fail++;
                    $display("FAIL basic_hi f%0d ch%0d: got %0d want %0d", f, c, hi[c], exp_hi[c]);
                end
            end
        end
    endtask

    task automatic test_clamp();
        int exp_old [6];
        int exp_new [6];
        exp_old = '{32, 52, 92, 40, 92, 68};
        exp_new = '{32, 52, 92, 40, 88, 68};
        // Written just after the boundary, so only the following frame sees them.
        servo2 = 7'd16;
        servo4 = 7'd14;
        count_frame(-1, 7'd0);
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (hi[c] !== exp_old[c]) begin
                n_fail++;
                $display("FAIL clamp_old ch%0d: got %0d want %0d", c, hi[c], exp_old[c]);
            end
        end
        count_frame(-1, 7'd0);
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (hi[c] !== exp_new[c]) begin
                n_fail++;
                $display("FAIL clamp_new ch%0d: got %0d want %0d", c, hi[c], exp_new[c]);
            end
        end
    endtask

    task automatic test_mid_frame_change();
        int exp3 [3];
        exp3 = '{40, 72, 48};
        count_frame(20, 7'd10);
        n_checks++;
        if (hi[3] !== exp3[0]) begin
            n_fail++;
            $display("FAIL midchg_same ch3: got %0d want %0d", hi[3], exp3[0]);
        end
        // Last cycle of the frame feeds the boundary, so 4 lands in the next frame.
        count_frame(127, 7'd4);
        n_checks++;
        if (hi[3] !== exp3[1]) begin
            n_fail++;
            $display("FAIL midchg_next ch3: got %0d want %0d", hi[3], exp3[1]);
        end
        count_frame(-1, 7'd0);
        n_checks++;
        if (hi[3] !== exp3[2] || fs_first !== 1) begin
            n_fail++;
            $display("FAIL midchg_boundary ch3: got %0d fs %0d want %0d fs 1",
                     hi[3], fs_first, exp3[2]);
        end
    endtask

    task automatic test_enable_drop();
        int busy;
        int exp_hi [6];
        exp_hi = '{32, 52, 92, 48, 88, 68};
        repeat (10) @(negedge clock);
        n_checks++;
        if (pwm_out !== 6'h3f) begin
            n_fail++;
            $display("FAIL endrop_before: got %h want 3f", pwm_out);
        end
        enable = 1'b0;
        @(negedge clock);
        n_checks++;
        if (pwm_out !== 6'h00 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL endrop_after: pwm %h fs %b want 00 0", pwm_out, frame_start);
        end
        busy = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (pwm_out !== 6'h00 || frame_start !== 1'b0) busy++;
        end
        n_checks++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL endrop_idle: active cycles %0d want 0", busy);
        end
        enable = 1'b1;
        @(negedge clock);
        count_frame(-1, 7'd0);
        n_checks++;
        if (fs_first !== 1 || fs_cnt !== 1) begin
            n_fail++;
            $display("FAIL reenable_fs: first %0d count %0d want 1 1", fs_first, fs_cnt);
        end
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (hi[c] !== exp_hi[c]) begin
                n_fail++;
                $display("FAIL reenable_hi ch%0d: got %0d want %0d", c, hi[c], exp_hi[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (50) @(negedge clock);
        ctrl_reset = 1'b1;
        servo0 = 7'd0; servo1 = 7'd0; servo2 = 7'd0;
        servo3 = 7'd0; servo4 = 7'd0; servo5 = 7'd0;
        @(negedge clock);
        n_checks++;
        if (pwm_out !== 6'h00 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_out: pwm %h fs %b want 00 0", pwm_out, frame_start);
        end
        ctrl_reset = 1'b0;
        @(negedge clock);
        count_frame(-1, 7'd0);
        n_checks++;
        if (fs_first !== 1 || fs_cnt !== 1) begin
            n_fail++;
            $display("FAIL rstmid_fs: first %0d count %0d want 1 1", fs_first, fs_cnt);
        end
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (hi[c] !== 32) begin
                n_fail++;
                $display("FAIL rstmid_hi ch%0d: got %0d want 32", c, hi[c]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_mid_frame_change();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
